// File: rtl/gamepad_pkg.sv
// Shared definitions for the serial gamepad poller:
// FSM state encodings and default parameter values.
package gamepad_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LATCH = 3'd1,
      ST_PHI   = 3'd2,
      ST_PLO   = 3'd3,
      ST_DONE  = 3'd4
   } padState_t;

   localparam int DEF_NUM_PADS      = 2;
   localparam int DEF_BUTTONS       = 8;
   localparam int DEF_CLK_DIV       = 600;
   localparam int DEF_POLL_INTERVAL = 200000;

endpackage

// File: rtl/gamepad_tick_gen.sv
// Protocol tick divider: counts 0..CLK_DIV-1, Tick on the last count.
// Clear restarts the count so every FSM state gets a full period.
module gamepad_tick_gen
   import gamepad_pkg::*;
#(
   parameter int CLK_DIV = DEF_CLK_DIV
) (
   input  logic Clock,
   input  logic Reset,
   input  logic Clear,
   output logic Tick
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] count;

   assign Tick = (count == CW'(CLK_DIV - 1));

   always_ff @(posedge Clock) begin
      if (Reset || Clear || Tick) begin
         count <= '0;
      end else begin
         count <= count + CW'(1);
      end
   end

endmodule

// File: rtl/gamepad_poller.sv
// Multi-pad NES-style latch/pulse poller with snapshot output,
// one-cycle Valid strobe and per-pad change flags.
module gamepad_poller
   import gamepad_pkg::*;
#(
   parameter int NUM_PADS      = DEF_NUM_PADS,
   parameter int BUTTONS       = DEF_BUTTONS,
   parameter int CLK_DIV       = DEF_CLK_DIV,
   parameter int POLL_INTERVAL = DEF_POLL_INTERVAL
) (
   input  logic                        Clock,
   input  logic                        Reset,
   input  logic [NUM_PADS-1:0]         GamePadData,
   input  logic                        Start,
   input  logic                        AutoPoll,
   output logic                        PadLatch,
   output logic                        PadPulse,
   output logic [NUM_PADS*BUTTONS-1:0] ButtonState,
   output logic                        Valid,
   output logic [NUM_PADS-1:0]         Changed,
   output logic                        Busy
);

   localparam int IDX_W = $clog2(BUTTONS);
   localparam int IW    = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
   localparam int SW    = NUM_PADS * BUTTONS;

   padState_t state, nextState;

   logic [NUM_PADS-1:0] padMeta, padSync;
   logic [IW-1:0]       intervalCnt;
   logic                intervalWrap;
   logic                pollReq;
   logic                tick, tickClear;
   logic                sampleEn, lastBit;
   logic [IDX_W-1:0]    bitIdx;
   logic [SW-1:0]       shiftBits, shiftNext;

   assign intervalWrap = (intervalCnt == IW'(POLL_INTERVAL - 1));
   assign pollReq      = Start | (AutoPoll & intervalWrap);
   assign sampleEn     = tick & ((state == ST_LATCH) | (state == ST_PLO));
   assign lastBit      = (bitIdx == IDX_W'(BUTTONS - 1));
   // Holding the divider clear in IDLE gives LATCH exactly CLK_DIV cycles.
   assign tickClear    = (nextState != state) | (state == ST_IDLE);

   gamepad_tick_gen #(
      .CLK_DIV(CLK_DIV)
   ) uTick (
      .Clock(Clock),
      .Reset(Reset),
      .Clear(tickClear),
      .Tick (tick)
   );

   always_comb begin
      nextState = state;
      unique case (state)
         ST_IDLE:  if (pollReq) nextState = ST_LATCH;
         ST_LATCH: if (tick)    nextState = ST_PHI;
         ST_PHI:   if (tick)    nextState = ST_PLO;
         ST_PLO:   if (tick)    nextState = lastBit ? ST_DONE : ST_PHI;
         ST_DONE:               nextState = ST_IDLE;
         default:               nextState = ST_IDLE;
      endcase
   end

   // Pads drive active-low; store as 1 = pressed.
   always_comb begin
      shiftNext = shiftBits;
      if (sampleEn) begin
         for (int p = 0; p < NUM_PADS; p++) begin
            shiftNext[p*BUTTONS + int'(bitIdx)] = ~padSync[p];
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state       <= ST_IDLE;
         padMeta     <= '0;
         padSync     <= '0;
         intervalCnt <= '0;
         bitIdx      <= '0;
         shiftBits   <= '0;
         PadLatch    <= 1'b0;
         PadPulse    <= 1'b0;
         Valid       <= 1'b0;
         Busy        <= 1'b0;
         ButtonState <= '0;
         Changed     <= '0;
      end else begin
         state     <= nextState;
         padMeta   <= GamePadData;
         padSync   <= padMeta;
         shiftBits <= shiftNext;

         intervalCnt <= intervalWrap ? '0 : intervalCnt + IW'(1);

         if (state == ST_IDLE) begin
            bitIdx <= '0;
         end else if (sampleEn) begin
            bitIdx <= bitIdx + IDX_W'(1);
         end

         PadLatch <= (nextState == ST_LATCH);
         PadPulse <= (nextState == ST_PHI);
         Valid    <= (nextState == ST_DONE);
         Busy     <= (nextState != ST_IDLE);

         if ((state == ST_PLO) && (nextState == ST_DONE)) begin
            ButtonState <= shiftNext;
            for (int p = 0; p < NUM_PADS; p++) begin
               Changed[p] <= (shiftNext[p*BUTTONS +: BUTTONS]
                              != ButtonState[p*BUTTONS +: BUTTONS]);
            end
         end
      end
   end

endmodule

// File: tb/tb_gamepad_poller.sv
// Self-checking bench for gamepad_poller with behavioural NES pad models
// and a snapshot-level reference model.
module tb_gamepad_poller;

   localparam int NP = 2;
   localparam int NB = 8;
   localparam int CD = 4;
   localparam int PI = 100;
   localparam int POLL_LEN = 1 + CD * (2 * NB - 1);

   logic           clk = 1'b0;
   logic           Reset;
   logic [NP-1:0]  GamePadData;
   logic           Start;
   logic           AutoPoll;
   logic           PadLatch;
   logic           PadPulse;
   logic [NP*NB-1:0] ButtonState;
   logic           Valid;
   logic [NP-1:0]  Changed;
   logic           Busy;

   int tests = 0;
   int fails = 0;

   logic [NB-1:0] padButtons [NP];
   logic [NB-1:0] padSr [NP];
   logic          pulseD;
   logic [NP*NB-1:0] prevExp;

   always #5 clk = ~clk;

   gamepad_poller #(
      .NUM_PADS     (NP),
      .BUTTONS      (NB),
      .CLK_DIV      (CD),
      .POLL_INTERVAL(PI)
   ) dut (
      .Clock      (clk),
      .Reset      (Reset),
      .GamePadData(GamePadData),
      .Start      (Start),
      .AutoPoll   (AutoPoll),
      .PadLatch   (PadLatch),
      .PadPulse   (PadPulse),
      .ButtonState(ButtonState),
      .Valid      (Valid),
      .Changed    (Changed),
      .Busy       (Busy)
   );

   // Pad: parallel load while latched, shift one bit per pulse rise.
   always @(posedge clk) begin
      pulseD <= PadPulse;
      for (int p = 0; p < NP; p++) begin
         if (Reset) padSr[p] <= '1;
         else if (PadLatch) padSr[p] <= ~padButtons[p];
         else if (PadPulse && !pulseD) padSr[p] <= {1'b1, padSr[p][NB-1:1]};
      end
   end

   always_comb begin
      for (int p = 0; p < NP; p++) GamePadData[p] = padSr[p][0];
   end

   function automatic logic [NP*NB-1:0] expState();
      logic [NP*NB-1:0] v;
      for (int p = 0; p < NP; p++) v[p*NB +: NB] = padButtons[p];
      return v;
   endfunction

   function automatic logic [NP-1:0] expChanged(input logic [NP*NB-1:0] nw,
                                                input logic [NP*NB-1:0] old);
      logic [NP-1:0] c;
      for (int p = 0; p < NP; p++) c[p] = (nw[p*NB +: NB] != old[p*NB +: NB]);
      return c;
   endfunction

   task automatic runPoll(input int rePulse, input int nCycles,
                          output int validAt, output int validCnt,
                          output int latchFirst, output int latchCnt,
                          output int pulseRises, output int busyCnt);
      logic prevPulse;
      validAt = -1; validCnt = 0; latchFirst = -1; latchCnt = 0;
      pulseRises = 0; busyCnt = 0; prevPulse = 1'b0;
      @(negedge clk);
      Start = 1'b1;
      @(posedge clk); #1;
      for (int n = 1; n <= nCycles; n++) begin
         if (n > 1) begin
            @(posedge clk); #1;
         end
         Start = (n == rePulse);
         if (PadLatch) begin
            latchCnt++;
            if (latchFirst < 0) latchFirst = n;
         end
         if (PadPulse && !prevPulse) pulseRises++;
         prevPulse = PadPulse;
         if (Busy) busyCnt++;
         if (Valid) begin
            validCnt++;
            if (validAt < 0) validAt = n;
         end
      end
      Start = 1'b0;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if ({PadLatch, PadPulse, Valid, Busy, Changed, ButtonState} !== '0) begin
         fails++;
         $display("FAIL reset_outputs got L%b P%b V%b B%b C%b S%h want all 0",
                  PadLatch, PadPulse, Valid, Busy, Changed, ButtonState);
      end
      Reset = 1'b0;
      prevExp = '0;
      @(posedge clk); #1;
   endtask

   task automatic test_single_poll();
      int va, vc, lf, lc, pr, bc;
      logic [NP*NB-1:0] e;
      padButtons[0] = 8'h09;
      padButtons[1] = 8'h00;
      e = expState();
      runPoll(0, 70, va, vc, lf, lc, pr, bc);
      tests++;
      if (lf !== 1 || lc !== CD) begin
         fails++;
         $display("FAIL single_latch first=%0d count=%0d want first=1 count=%0d",
                  lf, lc, CD);
      end
      tests++;
      if (pr !== NB - 1) begin
         fails++;
         $display("FAIL single_pulses got %0d want %0d", pr, NB - 1);
      end
      tests++;
      if (va !== POLL_LEN || vc !== 1) begin
         fails++;
         $display("FAIL single_valid at=%0d count=%0d want at=%0d count=1",
                  va, vc, POLL_LEN);
      end
      tests++;
      if (bc !== POLL_LEN) begin
         fails++;
         $display("FAIL single_busy got %0d cycles want %0d", bc, POLL_LEN);
      end
      tests++;
      if (ButtonState !== 16'h0009 || ButtonState !== e) begin
         fails++;
         $display("FAIL single_state got %h want %h", ButtonState, e);
      end
      tests++;
      if (Changed !== expChanged(e, prevExp)) begin
         fails++;
         $display("FAIL single_changed got %b want %b",
                  Changed, expChanged(e, prevExp));
      end
      prevExp = e;
   endtask

   task automatic test_repeat();
      int va, vc, lf, lc, pr, bc;
      logic [NP*NB-1:0] e;
      e = expState();
      runPoll(0, 70, va, vc, lf, lc, pr, bc);
      tests++;
      if (ButtonState !== e || Changed !== 2'b00) begin
         fails++;
         $display("FAIL repeat got S=%h C=%b want S=%h C=00",
                  ButtonState, Changed, e);
      end
      prevExp = e;
   endtask

   task automatic test_busy_ignore();
      int va, vc, lf, lc, pr, bc;
      runPoll(20, 140, va, vc, lf, lc, pr, bc);
      tests++;
      if (va !== POLL_LEN || vc !== 1 || lc !== CD) begin
         fails++;
         $display("FAIL busy_ignore valid_at=%0d valids=%0d latch=%0d want %0d/1/%0d",
                  va, vc, lc, POLL_LEN, CD);
      end
   endtask

   task automatic test_autopoll();
      int vt[$];
      logic [NP*NB-1:0] e;
      padButtons[0] = 8'($urandom);
      padButtons[1] = 8'($urandom);
      e = expState();
      AutoPoll = 1'b1;
      for (int n = 0; n < 360; n++) begin
         @(posedge clk); #1;
         if (Valid) begin
            vt.push_back(n);
            tests++;
            if (ButtonState !== e) begin
               fails++;
               $display("FAIL auto_state got %h want %h", ButtonState, e);
            end
         end
      end
      AutoPoll = 1'b0;
      tests++;
      if (vt.size() < 3) begin
         fails++;
         $display("FAIL auto_count got %0d valids want >=3", vt.size());
      end
      for (int i = 1; i < vt.size(); i++) begin
         tests++;
         if (vt[i] - vt[i-1] !== PI) begin
            fails++;
            $display("FAIL auto_period got %0d want %0d", vt[i] - vt[i-1], PI);
         end
      end
      repeat (80) @(posedge clk);
      #1;
      prevExp = e;
   endtask

   task automatic test_reset_midpoll();
      int va, vc, lf, lc, pr, bc;
      logic [NP*NB-1:0] e;
      @(negedge clk);
      Start = 1'b1;
      @(posedge clk); #1;
      Start = 1'b0;
      repeat (29) @(posedge clk);
      #1;
      Reset = 1'b1;
      @(posedge clk); #1;
      tests++;
      if ({PadLatch, PadPulse, Valid, Busy, Changed, ButtonState} !== '0) begin
         fails++;
         $display("FAIL midpoll_reset got L%b P%b V%b B%b C%b S%h want all 0",
                  PadLatch, PadPulse, Valid, Busy, Changed, ButtonState);
      end
      Reset = 1'b0;
      prevExp = '0;
      padButtons[0] = 8'h5A;
      padButtons[1] = 8'h81;
      e = expState();
      runPoll(0, 70, va, vc, lf, lc, pr, bc);
      tests++;
      if (va !== POLL_LEN || ButtonState !== e
          || Changed !== expChanged(e, prevExp)) begin
         fails++;
         $display("FAIL midpoll_repoll at=%0d S=%h C=%b want at=%0d S=%h C=%b",
                  va, ButtonState, Changed, POLL_LEN, e, expChanged(e, prevExp));
      end
      prevExp = e;
   endtask

   task automatic test_bit_order();
      int va, vc, lf, lc, pr, bc;
      logic [NP*NB-1:0] e;
      padButtons[0] = 8'h00;
      padButtons[1] = 8'hFF;
      e = expState();
      runPoll(0, 70, va, vc, lf, lc, pr, bc);
      tests++;
      if (ButtonState !== 16'hFF00 || Changed !== expChanged(e, prevExp)) begin
         fails++;
         $display("FAIL order_ff00 got S=%h C=%b want S=ff00 C=%b",
                  ButtonState, Changed, expChanged(e, prevExp));
      end
      prevExp = e;
      padButtons[0] = 8'h01;
      padButtons[1] = 8'h80;
      e = expState();
      runPoll(0, 70, va, vc, lf, lc, pr, bc);
      tests++;
      if (ButtonState !== 16'h8001) begin
         fails++;
         $display("FAIL order_8001 got %h want 8001", ButtonState);
      end
      prevExp = e;
   endtask

   task automatic test_random();
      int va, vc, lf, lc, pr, bc;
      logic [NP*NB-1:0] e;
      for (int i = 0; i < 10; i++) begin
         if (i % 3 != 2) begin
            padButtons[0] = 8'($urandom);
            padButtons[1] = 8'($urandom);
         end
         e = expState();
         runPoll(0, 66, va, vc, lf, lc, pr, bc);
         tests++;
         if (va !== POLL_LEN || vc !== 1 || ButtonState !== e
             || Changed !== expChanged(e, prevExp)) begin
            fails++;
            $display("FAIL random_%0d at=%0d n=%0d S=%h C=%b want at=%0d n=1 S=%h C=%b",
                     i, va, vc, ButtonState, Changed, POLL_LEN, e,
                     expChanged(e, prevExp));
         end
         prevExp = e;
      end
   endtask

   initial begin
      Reset = 1'b1;
      Start = 1'b0;
      AutoPoll = 1'b0;
      padButtons[0] = '0;
      padButtons[1] = '0;
      prevExp = '0;
      test_reset();
      test_single_poll();
      test_repeat();
      test_busy_ignore();
      test_autopoll();
      test_reset_midpoll();
      test_bit_order();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
